// File: rtl/int_to_fp_11_3_pkg.sv
// Shared constants, FloPoCo field layout and state encoding for the
// integer-to-FP(11,3) converter and its helpers.
package int_to_fp_11_3_pkg;

  localparam int WE   = 11;
  localparam int WF   = 3;
  localparam int BIAS = (1 << (WE - 1)) - 1;
  localparam int FP_W = WE + WF + 3;

  // FloPoCo exception field encodings
  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  // Bit offsets inside the FP word: {exn, sign, exp, frac}
  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = WF;
  localparam int SIGN_BIT = WE + WF;
  localparam int EXN_LSB  = WE + WF + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/int_to_fp_11_3_fp_round_ne.sv
// Round-to-nearest-even on a truncated fraction; a fraction carry-out
// bumps the exponent. Purely combinational, shared by FP producers.
module fp_round_ne #(
  parameter int WE = 11,
  parameter int WF = 3
) (
  input  logic [WF-1:0] frac_i,
  input  logic          guard_i,
  input  logic          sticky_i,
  input  logic [WE-1:0] exp_i,
  output logic [WF-1:0] frac_o,
  output logic [WE-1:0] exp_o
);

  logic          round_up;
  logic [WF:0]   frac_sum;

  // Ties (guard set, sticky clear) round up only when the kept LSB is odd.
  assign round_up = guard_i & (sticky_i | frac_i[0]);
  assign frac_sum = {1'b0, frac_i} + {{WF{1'b0}}, round_up};

  assign frac_o = frac_sum[WF-1:0];
  assign exp_o  = frac_sum[WF] ? (exp_i + WE'(1)) : exp_i;

endmodule

// File: rtl/int_to_fp_11_3.sv
// Signed integer to FloPoCo FP(11,3) converter: serial one-bit-per-cycle
// normalisation followed by a single rounding cycle, valid/ready on both sides.
module int_to_fp_11_3
  import int_to_fp_11_3_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_fp
);

  localparam logic [WE-1:0]   EXP_START = WE'(BIAS + IN_W - 1);
  localparam logic [IN_W-1:0] MAG_ONE   = IN_W'(1);

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [IN_W-1:0] mag_q, mag_d;
  logic [WE-1:0]   exp_q, exp_d;
  logic [FP_W-1:0] out_fp_q, out_fp_d;

  logic [WF-1:0]   rnd_frac_in;
  logic            rnd_guard;
  logic            rnd_sticky;
  logic [WF-1:0]   rnd_frac;
  logic [WE-1:0]   rnd_exp;

  // mag is normalised (MSB set) whenever ROUND is entered.
  assign rnd_frac_in = mag_q[IN_W-2 -: WF];
  assign rnd_guard   = mag_q[IN_W-2-WF];
  assign rnd_sticky  = |mag_q[IN_W-3-WF:0];

  fp_round_ne #(
    .WE (WE),
    .WF (WF)
  ) u_round (
    .frac_i   (rnd_frac_in),
    .guard_i  (rnd_guard),
    .sticky_i (rnd_sticky),
    .exp_i    (exp_q),
    .frac_o   (rnd_frac),
    .exp_o    (rnd_exp)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    out_fp_d = out_fp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_data[IN_W-1];
          mag_d  = in_data[IN_W-1] ? ((~in_data) + MAG_ONE) : in_data;
          exp_d  = EXP_START;
          if (in_data == '0) begin
            out_fp_d = {EXN_ZERO, 1'b0, {WE{1'b0}}, {WF{1'b0}}};
            state_d  = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (mag_q[IN_W-1]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[IN_W-2:0], 1'b0};
          exp_d = exp_q - WE'(1);
        end
      end
      ST_ROUND: begin
        exp_d    = rnd_exp;
        out_fp_d = {EXN_NORMAL, sign_q, rnd_exp, rnd_frac};
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      out_fp_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      out_fp_q <= out_fp_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_fp    = out_fp_q;

endmodule

// File: tb/tb_int_to_fp_11_3.sv
// Directed bench for int_to_fp_11_3: hand-computed FP words, latency,
// backpressure, ignored input during busy states and async reset.
module tb_int_to_fp_11_3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_fp;

  int errors = 0;
  int checks = 0;

  logic [16:0] res9, res5, res_tmp;

  always #5 clk = ~clk;

  int_to_fp_11_3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ordering of FloPoCo words restricted to zero/normal values.
  function automatic logic fp_gt(input logic [16:0] a, input logic [16:0] b);
    logic [15:0] ma, mb;
    ma = {a[16:15], a[13:0]};
    mb = {b[16:15], b[13:0]};
    if (a[14] != b[14]) return b[14];
    if (!a[14])         return ma > mb;
    return ma < mb;
  endfunction

  // One full conversion: accept, wait (bounded) for out_valid, hold under
  // backpressure, then complete the output handshake.
  task automatic run_conv(input string tag, input logic [15:0] din, input logic [16:0] exp_fp,
                          input int exp_lat, input int hold, input logic junk,
                          output logic [16:0] res);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk);
    in_valid = junk;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (junk) begin
        check({tag, " in_ready busy"}, in_ready, 0);
        in_data = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " out_fp"}, out_fp, exp_fp);
    res = out_fp;
    for (int i = 0; i < hold; i++) begin
      if (junk) in_data = 16'($urandom);
      @(negedge clk);
    end
    if (hold > 0) begin
      check({tag, " valid held"}, out_valid, 1);
      check({tag, " fp held"}, out_fp, exp_fp);
      check({tag, " in_ready done"}, in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " ready back"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_fp", out_fp, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_conv("one",   16'h0001, 17'h09FF8, 17, 5, 1'b0, res_tmp);
    run_conv("neg3",  16'hFFFD, 17'h0E004, 16, 0, 1'b0, res_tmp);
    run_conv("min",   16'h8000, 17'h0E070,  2, 1, 1'b0, res_tmp);
    run_conv("nine",  16'h0009, 17'h0A011, 14, 0, 1'b0, res9);
    run_conv("tie17", 16'h0011, 17'h0A018, 13, 0, 1'b0, res_tmp);
    run_conv("max",   16'h7FFF, 17'h0A070,  3, 0, 1'b0, res_tmp);
    run_conv("zero",  16'h0000, 17'h00000,  0, 2, 1'b0, res_tmp);
    run_conv("five",  16'h0005, 17'h0A00A, 15, 3, 1'b1, res5);
    run_conv("neg3b", 16'hFFFD, 17'h0E004, 16, 2, 1'b1, res_tmp);

    // Asynchronous reset between clock edges while normalising.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset in_ready", in_ready, 1);
    check("midreset out_fp", out_fp, 0);
    @(negedge clk);
    rst = 1'b1;
    run_conv("post_reset", 16'h0009, 17'h0A011, 14, 0, 1'b0, res_tmp);

    check("gt 9>5", fp_gt(res9, res5), 1);
    check("gt 5>9", fp_gt(res5, res9), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
